id_exe_stage_reg: RTL and testbench
===================================

// Module: id_exe_stage_reg
// PURPOSE
//  ID->EXE pipeline register of the ARM core. Captures decoded control fields and the operand values
//  read from the register file (Val_Rn/Val_Rm). Supports hazard freeze and branch flush.
//  While frozen, held operands are refreshed from the writeback bus so a stalled instruction never
//  carries a value the register file has since overwritten.
// PARAMETERS
//  DATA_W      32  operand / PC width
//  REG_AW      4   register index width (R0..R14 in the file; R15 = PC, never stored)
//  CMD_W       4   EXE_CMD width
// PORTS
//  clk               in   1       rising-edge clock
//  rst               in   1       synchronous, active-high reset
//  flush             in   1       kill the instruction being captured (taken branch)
//  freeze            in   1       hold all outputs (hazard stall)
//  valid_in          in   1       ID stage presents a real instruction
//  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in 1 each  decoded control bits
//  exe_cmd_in        in   CMD_W   ALU command
//  pc_in             in   DATA_W  PC+4 of instruction
//  val_rn_in, val_rm_in in DATA_W  register file reg1/reg2
//  shift_operand_in  in   12      shifter operand field
//  signed_imm24_in   in   24      branch offset
//  dest_in, src1_in, src2_in in REG_AW  destination / source indices
//  sr_in             in   4       status flags NZCV
//  wb_wb_en          in   1       writeback bus enable (same signal driving register file writeBackEn)
//  wb_dest           in   REG_AW  writeback index (Dest_wb)
//  wb_value          in   DATA_W  writeback data (Result_WB)
//  valid_out, *_out  out  same widths as corresponding inputs, registered
// BEHAVIOUR
//  - Priority per rising edge: rst > flush > freeze > load.
//  - rst: every output = 0, including valid_out.
//  - flush (freeze ignored): valid_out=0, wb_en/mem_r_en/mem_w_en/b/s_out=0. All other fields = 0.
//    Bubble is harmless downstream.
//  - freeze & !flush: all outputs hold, except operand refresh (below).
//  - load (!flush & !freeze): every *_out <= *_in next edge; valid_out <= valid_in. Latency 1 cycle.
//    When valid_in=0, control enables load as 0, regardless of their inputs.
//  - Operand refresh, only while frozen and valid_out=1:
//      if wb_wb_en & wb_dest==src1_out & src1_out!=4'hF  -> val_rn_out <= wb_value
//      if wb_wb_en & wb_dest==src2_out & src2_out!=4'hF  -> val_rm_out <= wb_value
//      both matches in one cycle -> both update with the same wb_value.
//  - No refresh on load.
//    The register file writes on the falling edge, so reg1/reg2 are already current at capture.
//  - Freeze held for N cycles: refresh applies on each of the N edges; the last write wins.
//  - Reset asserted mid-freeze or mid-flush: reset wins on that edge; next edge behaves per inputs.
//  - sr_out captured only on load; never refreshed (flags are forwarded separately).
// STRUCTURE
//  - Shared package arm_pkg: EXE_CMD encodings, REG_PC = 4'hF, DATA_W / REG_AW / CMD_W constants.
//  - One sub-module: operand_refresh.
//    Comparator + mux: inputs src_idx, held_val, wb_wb_en, wb_dest, wb_value; output next_val.
//    Instantiated twice (Rn, Rm).
//  - Control fields in one always block with the priority chain; no other state.
// TESTING
//  1 rst=1 for 2 cycles with all inputs 0xFF.. -> all outputs 0, valid_out=0.
//  2 load: valid_in=1, val_rn_in=0x1234, dest_in=3, wb_en_in=1 -> next edge val_rn_out=0x1234,
//    dest_out=3, wb_en_out=1.
//  3 freeze=1, src1_out=5, wb_wb_en=1, wb_dest=5, wb_value=0xDEAD -> val_rn_out=0xDEAD,
//    all other fields held.
//  4 freeze=1, src1_out=src2_out=7, wb_dest=7, wb_value=0x77 -> both operands 0x77;
//    wb_dest=15 with src1_out=15 -> no change.
//  5 flush=1 & freeze=1, mem_w_en_in=1 -> valid_out=0, mem_w_en_out=0, all outputs 0.
//  6 freeze 3 cycles, wb writes R2 with 0x10, 0x20, 0x30; src2_out=2 -> val_rm_out=0x30;
//    then rst mid-freeze -> all outputs 0.

Source files
------------

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared ARM core definitions: widths, EXE_CMD encodings, ID->EXE bundle.
// Also provides the writeback-hit helper used by operand refresh.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CMD_W  = 4;

  localparam logic [REG_AW-1:0] REG_PC = 4'hF;

  typedef enum logic [CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  typedef struct packed {
    ctrl_t              ctrl;
    logic               imm;
    logic [CMD_W-1:0]   exe_cmd;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  val_rn;
    logic [DATA_W-1:0]  val_rm;
    logic [11:0]        shift_operand;
    logic [23:0]        signed_imm24;
    logic [REG_AW-1:0]  dest;
    logic [REG_AW-1:0]  src1;
    logic [REG_AW-1:0]  src2;
    logic [3:0]         sr;
  } id_exe_t;

  // R15 is the PC and never lives in the file, so it never matches.
  function automatic logic wb_hit(
    input logic              en,
    input logic [REG_AW-1:0] dest,
    input logic [REG_AW-1:0] src
  );
    return en && (dest == src) && (src != REG_PC);
  endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE stage bundle: ID-side fields, writeback bus, EXE-side fields.
// master = producer/consumer around the stage, slave = the stage itself.
interface id_exe_stage_reg_if
  import arm_pkg::*;
();

  logic              flush;
  logic              freeze;
  logic              valid_in;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              b_in;
  logic              s_in;
  logic              imm_in;
  logic [CMD_W-1:0]  exe_cmd_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] val_rn_in;
  logic [DATA_W-1:0] val_rm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm24_in;
  logic [REG_AW-1:0] dest_in;
  logic [REG_AW-1:0] src1_in;
  logic [REG_AW-1:0] src2_in;
  logic [3:0]        sr_in;

  logic              wb_wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;

  logic              valid_out;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic              mem_w_en_out;
  logic              b_out;
  logic              s_out;
  logic              imm_out;
  logic [CMD_W-1:0]  exe_cmd_out;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] val_rn_out;
  logic [DATA_W-1:0] val_rm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm24_out;
  logic [REG_AW-1:0] dest_out;
  logic [REG_AW-1:0] src1_out;
  logic [REG_AW-1:0] src2_out;
  logic [3:0]        sr_out;

  modport master (
    output flush, freeze, valid_in,
    output wb_en_in, mem_r_en_in, mem_w_en_in,
    output b_in, s_in, imm_in, exe_cmd_in,
    output pc_in, val_rn_in, val_rm_in,
    output shift_operand_in, signed_imm24_in,
    output dest_in, src1_in, src2_in, sr_in,
    output wb_wb_en, wb_dest, wb_value,
    input  valid_out,
    input  wb_en_out, mem_r_en_out, mem_w_en_out,
    input  b_out, s_out, imm_out, exe_cmd_out,
    input  pc_out, val_rn_out, val_rm_out,
    input  shift_operand_out, signed_imm24_out,
    input  dest_out, src1_out, src2_out, sr_out
  );

  modport slave (
    input  flush, freeze, valid_in,
    input  wb_en_in, mem_r_en_in, mem_w_en_in,
    input  b_in, s_in, imm_in, exe_cmd_in,
    input  pc_in, val_rn_in, val_rm_in,
    input  shift_operand_in, signed_imm24_in,
    input  dest_in, src1_in, src2_in, sr_in,
    input  wb_wb_en, wb_dest, wb_value,
    output valid_out,
    output wb_en_out, mem_r_en_out, mem_w_en_out,
    output b_out, s_out, imm_out, exe_cmd_out,
    output pc_out, val_rn_out, val_rm_out,
    output shift_operand_out, signed_imm24_out,
    output dest_out, src1_out, src2_out, sr_out
  );

endinterface

// File: rtl/id_exe_stage_reg_operand_refresh.sv
// operand_refresh: picks the writeback value for a held operand on a hit.
// Ports: i_src_idx, i_held_val, i_wb_wb_en, i_wb_dest, i_wb_value -> o_next_val.
module operand_refresh
  import arm_pkg::*;
(
  input  logic [REG_AW-1:0] i_src_idx,
  input  logic [DATA_W-1:0] i_held_val,
  input  logic              i_wb_wb_en,
  input  logic [REG_AW-1:0] i_wb_dest,
  input  logic [DATA_W-1:0] i_wb_value,
  output logic [DATA_W-1:0] o_next_val
);

  logic w_hit;

  assign w_hit = wb_hit(i_wb_wb_en, i_wb_dest, i_src_idx);

  assign o_next_val = w_hit ? i_wb_value : i_held_val;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze, flush and frozen-operand refresh.
// Ports: clk, rst (sync, active-high), io_bus (id_exe_stage_reg_if.slave).
module id_exe_stage_reg
  import arm_pkg::*;
(
  input logic               clk,
  input logic               rst,
  id_exe_stage_reg_if.slave io_bus
);

  id_exe_t           r_q;
  logic              r_valid;
  id_exe_t           w_d;
  logic [DATA_W-1:0] w_rn_next;
  logic [DATA_W-1:0] w_rm_next;

  // A non-instruction must not enable any side effect downstream.
  always_comb begin
    w_d               = '0;
    if (io_bus.valid_in) begin
      w_d.ctrl.wb_en    = io_bus.wb_en_in;
      w_d.ctrl.mem_r_en = io_bus.mem_r_en_in;
      w_d.ctrl.mem_w_en = io_bus.mem_w_en_in;
      w_d.ctrl.b        = io_bus.b_in;
      w_d.ctrl.s        = io_bus.s_in;
    end
    w_d.imm           = io_bus.imm_in;
    w_d.exe_cmd       = io_bus.exe_cmd_in;
    w_d.pc            = io_bus.pc_in;
    w_d.val_rn        = io_bus.val_rn_in;
    w_d.val_rm        = io_bus.val_rm_in;
    w_d.shift_operand = io_bus.shift_operand_in;
    w_d.signed_imm24  = io_bus.signed_imm24_in;
    w_d.dest          = io_bus.dest_in;
    w_d.src1          = io_bus.src1_in;
    w_d.src2          = io_bus.src2_in;
    w_d.sr            = io_bus.sr_in;
  end

  operand_refresh u_rn (
    .i_src_idx  (r_q.src1),
    .i_held_val (r_q.val_rn),
    .i_wb_wb_en (io_bus.wb_wb_en),
    .i_wb_dest  (io_bus.wb_dest),
    .i_wb_value (io_bus.wb_value),
    .o_next_val (w_rn_next)
  );

  operand_refresh u_rm (
    .i_src_idx  (r_q.src2),
    .i_held_val (r_q.val_rm),
    .i_wb_wb_en (io_bus.wb_wb_en),
    .i_wb_dest  (io_bus.wb_dest),
    .i_wb_value (io_bus.wb_value),
    .o_next_val (w_rm_next)
  );

  // Freeze holds everything except operands of a live instruction,
  // which track the writeback bus so they never go stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (io_bus.flush) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (io_bus.freeze) begin
      if (r_valid) begin
        r_q.val_rn <= w_rn_next;
        r_q.val_rm <= w_rm_next;
      end
    end else begin
      r_valid <= io_bus.valid_in;
      r_q     <= w_d;
    end
  end

  assign io_bus.valid_out         = r_valid;
  assign io_bus.wb_en_out         = r_q.ctrl.wb_en;
  assign io_bus.mem_r_en_out      = r_q.ctrl.mem_r_en;
  assign io_bus.mem_w_en_out      = r_q.ctrl.mem_w_en;
  assign io_bus.b_out             = r_q.ctrl.b;
  assign io_bus.s_out             = r_q.ctrl.s;
  assign io_bus.imm_out           = r_q.imm;
  assign io_bus.exe_cmd_out       = r_q.exe_cmd;
  assign io_bus.pc_out            = r_q.pc;
  assign io_bus.val_rn_out        = r_q.val_rn;
  assign io_bus.val_rm_out        = r_q.val_rm;
  assign io_bus.shift_operand_out = r_q.shift_operand;
  assign io_bus.signed_imm24_out  = r_q.signed_imm24;
  assign io_bus.dest_out          = r_q.dest;
  assign io_bus.src1_out          = r_q.src1;
  assign io_bus.src2_out          = r_q.src2;
  assign io_bus.sr_out            = r_q.sr;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg.
// Covers reset, load, freeze refresh, flush, invalid load, long freeze.
module tb_id_exe_stage_reg;
  import arm_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_exe_stage_reg_if u_if ();

  id_exe_stage_reg dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    u_if.flush            = 1'b0;
    u_if.freeze           = 1'b0;
    u_if.valid_in         = 1'b0;
    u_if.wb_en_in         = 1'b0;
    u_if.mem_r_en_in      = 1'b0;
    u_if.mem_w_en_in      = 1'b0;
    u_if.b_in             = 1'b0;
    u_if.s_in             = 1'b0;
    u_if.imm_in           = 1'b0;
    u_if.exe_cmd_in       = '0;
    u_if.pc_in            = '0;
    u_if.val_rn_in        = '0;
    u_if.val_rm_in        = '0;
    u_if.shift_operand_in = '0;
    u_if.signed_imm24_in  = '0;
    u_if.dest_in          = '0;
    u_if.src1_in          = '0;
    u_if.src2_in          = '0;
    u_if.sr_in            = '0;
    u_if.wb_wb_en         = 1'b0;
    u_if.wb_dest          = '0;
    u_if.wb_value         = '0;
  endtask

  task automatic test_reset;
    u_if.flush            = 1'b1;
    u_if.freeze           = 1'b1;
    u_if.valid_in         = 1'b1;
    u_if.wb_en_in         = 1'b1;
    u_if.mem_r_en_in      = 1'b1;
    u_if.mem_w_en_in      = 1'b1;
    u_if.b_in             = 1'b1;
    u_if.s_in             = 1'b1;
    u_if.imm_in           = 1'b1;
    u_if.exe_cmd_in       = '1;
    u_if.pc_in            = '1;
    u_if.val_rn_in        = '1;
    u_if.val_rm_in        = '1;
    u_if.shift_operand_in = '1;
    u_if.signed_imm24_in  = '1;
    u_if.dest_in          = '1;
    u_if.src1_in          = '1;
    u_if.src2_in          = '1;
    u_if.sr_in            = '1;
    u_if.wb_wb_en         = 1'b1;
    u_if.wb_dest          = '1;
    u_if.wb_value         = '1;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (u_if.valid_out !== 1'b0) begin
      $display("FAIL rst_valid got=%b exp=0", u_if.valid_out);
      failures++;
    end
    checks++;
    if ({u_if.wb_en_out, u_if.mem_r_en_out, u_if.mem_w_en_out,
         u_if.b_out, u_if.s_out, u_if.imm_out} !== 6'b0) begin
      $display("FAIL rst_ctrl got=%b%b%b%b%b%b exp=000000",
               u_if.wb_en_out, u_if.mem_r_en_out, u_if.mem_w_en_out,
               u_if.b_out, u_if.s_out, u_if.imm_out);
      failures++;
    end
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out, u_if.pc_out} !== 96'h0) begin
      $display("FAIL rst_data got=%h %h %h exp=0",
               u_if.val_rn_out, u_if.val_rm_out, u_if.pc_out);
      failures++;
    end
    checks++;
    if ({u_if.exe_cmd_out, u_if.dest_out, u_if.src1_out, u_if.src2_out,
         u_if.sr_out, u_if.shift_operand_out,
         u_if.signed_imm24_out} !== 56'h0) begin
      $display("FAIL rst_fields got=%h %h %h %h %h %h %h exp=0",
               u_if.exe_cmd_out, u_if.dest_out, u_if.src1_out,
               u_if.src2_out, u_if.sr_out, u_if.shift_operand_out,
               u_if.signed_imm24_out);
      failures++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load;
    clear_inputs();
    u_if.valid_in         = 1'b1;
    u_if.wb_en_in         = 1'b1;
    u_if.val_rn_in        = 32'h1234;
    u_if.val_rm_in        = 32'h5678;
    u_if.dest_in          = 4'd3;
    u_if.src1_in          = 4'd5;
    u_if.src2_in          = 4'd6;
    u_if.pc_in            = 32'h104;
    u_if.sr_in            = 4'hA;
    u_if.exe_cmd_in       = EXE_ADD;
    u_if.shift_operand_in = 12'h0AB;
    u_if.signed_imm24_in  = 24'h123456;
    tick();
    checks++;
    if ({u_if.valid_out, u_if.wb_en_out, u_if.dest_out}
        !== {1'b1, 1'b1, 4'd3}) begin
      $display("FAIL load_ctrl got=%b %b %h exp=1 1 3",
               u_if.valid_out, u_if.wb_en_out, u_if.dest_out);
      failures++;
    end
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out}
        !== {32'h1234, 32'h5678}) begin
      $display("FAIL load_ops got=%h %h exp=1234 5678",
               u_if.val_rn_out, u_if.val_rm_out);
      failures++;
    end
    checks++;
    if ({u_if.pc_out, u_if.sr_out, u_if.exe_cmd_out, u_if.src1_out,
         u_if.src2_out, u_if.shift_operand_out, u_if.signed_imm24_out}
        !== {32'h104, 4'hA, 4'b0010, 4'd5, 4'd6, 12'h0AB,
             24'h123456}) begin
      $display("FAIL load_fields got=%h %h %h %h %h %h %h",
               u_if.pc_out, u_if.sr_out, u_if.exe_cmd_out,
               u_if.src1_out, u_if.src2_out, u_if.shift_operand_out,
               u_if.signed_imm24_out);
      failures++;
    end
  endtask

  task automatic test_freeze_refresh;
    u_if.freeze      = 1'b1;
    u_if.val_rn_in   = 32'hFFFF_FFFF;
    u_if.dest_in     = 4'd9;
    u_if.pc_in       = 32'h200;
    u_if.sr_in       = 4'h5;
    u_if.wb_en_in    = 1'b0;
    u_if.mem_r_en_in = 1'b1;
    u_if.wb_wb_en    = 1'b1;
    u_if.wb_dest     = 4'd5;
    u_if.wb_value    = 32'hDEAD;
    tick();
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out}
        !== {32'hDEAD, 32'h5678}) begin
      $display("FAIL frz_rn got=%h %h exp=dead 5678",
               u_if.val_rn_out, u_if.val_rm_out);
      failures++;
    end
    checks++;
    if ({u_if.valid_out, u_if.wb_en_out, u_if.mem_r_en_out,
         u_if.dest_out, u_if.pc_out, u_if.sr_out}
        !== {1'b1, 1'b1, 1'b0, 4'd3, 32'h104, 4'hA}) begin
      $display("FAIL frz_hold got=%b %b %b %h %h %h exp=1 1 0 3 104 a",
               u_if.valid_out, u_if.wb_en_out, u_if.mem_r_en_out,
               u_if.dest_out, u_if.pc_out, u_if.sr_out);
      failures++;
    end
    u_if.wb_wb_en = 1'b0;
    u_if.wb_value = 32'hBEEF;
    tick();
    checks++;
    if (u_if.val_rn_out !== 32'hDEAD) begin
      $display("FAIL frz_noen got=%h exp=dead", u_if.val_rn_out);
      failures++;
    end
  endtask

  task automatic test_dual_refresh;
    clear_inputs();
    u_if.valid_in  = 1'b1;
    u_if.src1_in   = 4'd7;
    u_if.src2_in   = 4'd7;
    u_if.val_rn_in = 32'h1;
    u_if.val_rm_in = 32'h2;
    u_if.wb_wb_en  = 1'b1;
    u_if.wb_dest   = 4'd7;
    u_if.wb_value  = 32'h55;
    tick();
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out} !== {32'h1, 32'h2}) begin
      $display("FAIL load_norefresh got=%h %h exp=1 2",
               u_if.val_rn_out, u_if.val_rm_out);
      failures++;
    end
    u_if.freeze   = 1'b1;
    u_if.wb_value = 32'h77;
    tick();
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out} !== {32'h77, 32'h77}) begin
      $display("FAIL dual got=%h %h exp=77 77",
               u_if.val_rn_out, u_if.val_rm_out);
      failures++;
    end
    u_if.freeze    = 1'b0;
    u_if.wb_wb_en  = 1'b0;
    u_if.src1_in   = 4'hF;
    u_if.src2_in   = 4'hF;
    u_if.val_rn_in = 32'hAA;
    u_if.val_rm_in = 32'hBB;
    tick();
    u_if.freeze   = 1'b1;
    u_if.wb_wb_en = 1'b1;
    u_if.wb_dest  = 4'hF;
    u_if.wb_value = 32'h99;
    tick();
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out} !== {32'hAA, 32'hBB}) begin
      $display("FAIL r15 got=%h %h exp=aa bb",
               u_if.val_rn_out, u_if.val_rm_out);
      failures++;
    end
  endtask

  task automatic test_flush;
    u_if.flush       = 1'b1;
    u_if.freeze      = 1'b1;
    u_if.valid_in    = 1'b1;
    u_if.mem_w_en_in = 1'b1;
    u_if.val_rn_in   = 32'h33;
    u_if.dest_in     = 4'd2;
    u_if.pc_in       = 32'h300;
    tick();
    checks++;
    if ({u_if.valid_out, u_if.mem_w_en_out} !== 2'b00) begin
      $display("FAIL flush_ctrl got=%b %b exp=0 0",
               u_if.valid_out, u_if.mem_w_en_out);
      failures++;
    end
    checks++;
    if ({u_if.val_rn_out, u_if.val_rm_out, u_if.pc_out, u_if.dest_out,
         u_if.src1_out, u_if.src2_out, u_if.sr_out} !== 112'h0) begin
      $display("FAIL flush_zero got=%h %h %h %h %h %h %h exp=0",
               u_if.val_rn_out, u_if.val_rm_out, u_if.pc_out,
               u_if.dest_out, u_if.src1_out, u_if.src2_out,
               u_if.sr_out);
      failures++;
    end
  endtask

  task automatic test_invalid_load;
    clear_inputs();
    u_if.wb_en_in    = 1'b1;
    u_if.mem_r_en_in = 1'b1;
    u_if.mem_w_en_in = 1'b1;
    u_if.b_in        = 1'b1;
    u_if.s_in        = 1'b1;
    u_if.imm_in      = 1'b1;
    u_if.dest_in     = 4'd4;
    u_if.src1_in     = 4'd4;
    u_if.val_rn_in   = 32'h44;
    tick();
    checks++;
    if ({u_if.valid_out, u_if.wb_en_out, u_if.mem_r_en_out,
         u_if.mem_w_en_out, u_if.b_out, u_if.s_out} !== 6'b0) begin
      $display("FAIL inv_ctrl got=%b%b%b%b%b%b exp=000000",
               u_if.valid_out, u_if.wb_en_out, u_if.mem_r_en_out,
               u_if.mem_w_en_out, u_if.b_out, u_if.s_out);
      failures++;
    end
    checks++;
    if ({u_if.imm_out, u_if.dest_out, u_if.val_rn_out}
        !== {1'b1, 4'd4, 32'h44}) begin
      $display("FAIL inv_fields got=%b %h %h exp=1 4 44",
               u_if.imm_out, u_if.dest_out, u_if.val_rn_out);
      failures++;
    end
    u_if.freeze   = 1'b1;
    u_if.wb_wb_en = 1'b1;
    u_if.wb_dest  = 4'd4;
    u_if.wb_value = 32'h99;
    tick();
    checks++;
    if (u_if.val_rn_out !== 32'h44) begin
      $display("FAIL inv_norefresh got=%h exp=44", u_if.val_rn_out);
      failures++;
    end
  endtask

  task automatic test_freeze_multi;
    logic [31:0] vals [3];
    vals[0] = 32'h10;
    vals[1] = 32'h20;
    vals[2] = 32'h30;
    clear_inputs();
    u_if.valid_in  = 1'b1;
    u_if.src1_in   = 4'd3;
    u_if.src2_in   = 4'd2;
    u_if.val_rn_in = 32'hC;
    u_if.val_rm_in = 32'h5;
    tick();
    u_if.freeze   = 1'b1;
    u_if.wb_wb_en = 1'b1;
    u_if.wb_dest  = 4'd2;
    for (int i = 0; i < 3; i++) begin
      u_if.wb_value = vals[i];
      tick();
      checks++;
      if ({u_if.val_rm_out, u_if.val_rn_out} !== {vals[i], 32'hC}) begin
        $display("FAIL multi_%0d got=%h %h exp=%h c", i,
                 u_if.val_rm_out, u_if.val_rn_out, vals[i]);
        failures++;
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({u_if.valid_out, u_if.val_rm_out, u_if.val_rn_out,
         u_if.src1_out, u_if.src2_out} !== 73'h0) begin
      $display("FAIL rst_mid got=%b %h %h %h %h exp=0",
               u_if.valid_out, u_if.val_rm_out, u_if.val_rn_out,
               u_if.src1_out, u_if.src2_out);
      failures++;
    end
    rst           = 1'b0;
    u_if.freeze   = 1'b0;
    u_if.dest_in  = 4'd6;
    tick();
    checks++;
    if ({u_if.valid_out, u_if.dest_out} !== {1'b1, 4'd6}) begin
      $display("FAIL post_rst got=%b %h exp=1 6",
               u_if.valid_out, u_if.dest_out);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_load();
    test_freeze_refresh();
    test_dual_refresh();
    test_flush();
    test_invalid_load();
    test_freeze_multi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
